// File: rtl/adau1761_i2s_if.sv
// Playback, capture and I2S pin bundle between the serial port and its users.
// master = the I2S port itself, slave = sample source/sink and codec pins.
interface adau1761_i2s_if #(
  parameter int unsigned SAMPLE_W = 24
);
  logic                enable;
  logic [SAMPLE_W-1:0] tx_left;
  logic [SAMPLE_W-1:0] tx_right;
  logic                tx_valid;
  logic                tx_ready;
  logic                tx_underrun;
  logic [SAMPLE_W-1:0] rx_left;
  logic [SAMPLE_W-1:0] rx_right;
  logic                rx_valid;
  logic                i2s_bclk;
  logic                i2s_lrclk;
  logic                i2s_sdata_o;
  logic                i2s_sdata_i;

  modport master (
    input  enable, tx_left, tx_right, tx_valid, i2s_sdata_i,
    output tx_ready, tx_underrun, rx_left, rx_right, rx_valid,
           i2s_bclk, i2s_lrclk, i2s_sdata_o
  );

  modport slave (
    output enable, tx_left, tx_right, tx_valid, i2s_sdata_i,
    input  tx_ready, tx_underrun, rx_left, rx_right, rx_valid,
           i2s_bclk, i2s_lrclk, i2s_sdata_o
  );
endinterface

// File: rtl/adau1761_i2s_port.sv
// Full-duplex I2S master for the ADAU1761: BCLK/LRCLK generation, 2x SLOT_W frame,
// MSB-first SAMPLE_W data with one-BCLK delay, one-pair playback holding register.
module adau1761_i2s_port #(
  parameter int unsigned BCLK_HALF = 8,
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned SLOT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  adau1761_i2s_if.master bus
);

  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned DIV_W   = $clog2(BCLK_HALF);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] L_FIRST  = BIT_W'(1);
  localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(SAMPLE_W);
  localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(SLOT_W + 1);
  localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(SLOT_W + SAMPLE_W);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic [FRAME_W-1:0]  tx_sr_q, tx_sr_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic                underrun_q, underrun_d;
  logic [SAMPLE_W-1:0] rx_l_sr_q, rx_l_sr_d;
  logic [SAMPLE_W-1:0] rx_r_sr_q, rx_r_sr_d;
  logic                rx_pend_q, rx_pend_d;
  logic [SAMPLE_W-1:0] rx_left_q, rx_left_d;
  logic [SAMPLE_W-1:0] rx_right_q, rx_right_d;
  logic                rx_valid_q, rx_valid_d;

  logic                tick, rise_ev, fall_ev, frame_start, tx_ready, accept;
  logic [BIT_W-1:0]    bit_nxt;
  logic [SAMPLE_W-1:0] ld_l, ld_r;

  assign tx_ready = bus.enable & ~hold_full_q;
  assign accept   = bus.tx_valid & tx_ready;

  // Next-state logic: divider, frame counter, tx load/shift, rx capture
  always_comb begin
    tick        = bus.enable && (div_cnt_q == DIV_LAST);
    rise_ev     = tick & ~bclk_q;
    fall_ev     = tick & bclk_q;
    bit_nxt     = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    frame_start = fall_ev && (bit_nxt == '0);
    ld_l        = '0;
    ld_r        = '0;

    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    tx_sr_d     = tx_sr_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    underrun_d  = 1'b0;
    rx_l_sr_d   = rx_l_sr_q;
    rx_r_sr_d   = rx_r_sr_q;
    rx_pend_d   = 1'b0;
    rx_left_d   = rx_left_q;
    rx_right_d  = rx_right_q;
    rx_valid_d  = 1'b0;

    if (!bus.enable) begin
      div_cnt_d   = '0;
      bit_cnt_d   = BIT_LAST;
      bclk_d      = 1'b0;
      lrclk_d     = 1'b0;
      sdata_d     = 1'b0;
      tx_sr_d     = '0;
      hold_full_d = 1'b0;
      rx_l_sr_d   = '0;
      rx_r_sr_d   = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      if (tick) bclk_d = ~bclk_q;

      // Frame-start source priority: held pair, same-clk bypass, then silence
      if (frame_start) begin
        if (hold_full_q) begin
          ld_l        = hold_l_q;
          ld_r        = hold_r_q;
          hold_full_d = 1'b0;
        end else if (accept) begin
          ld_l = bus.tx_left;
          ld_r = bus.tx_right;
        end else begin
          underrun_d = 1'b1;
        end
      end else if (accept) begin
        hold_l_d    = bus.tx_left;
        hold_r_d    = bus.tx_right;
        hold_full_d = 1'b1;
      end

      if (fall_ev) begin
        bit_cnt_d = bit_nxt;
        lrclk_d   = (bit_nxt >= SLOT_B);
        if (frame_start) begin
          sdata_d = 1'b0;
          tx_sr_d = '0;
          tx_sr_d[FRAME_W-1 -: SAMPLE_W] = ld_l;
          tx_sr_d[SLOT_W-1 -: SAMPLE_W]  = ld_r;
        end else begin
          sdata_d = tx_sr_q[FRAME_W-1];
          tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
        end
      end

      // Capture on rising BCLK, while the codec holds the bit stable
      if (rise_ev) begin
        if (bit_cnt_q >= L_FIRST && bit_cnt_q <= L_LAST)
          rx_l_sr_d = {rx_l_sr_q[SAMPLE_W-2:0], bus.i2s_sdata_i};
        if (bit_cnt_q >= R_FIRST && bit_cnt_q <= R_LAST)
          rx_r_sr_d = {rx_r_sr_q[SAMPLE_W-2:0], bus.i2s_sdata_i};
        if (bit_cnt_q == R_LAST) rx_pend_d = 1'b1;
      end

      if (rx_pend_q) begin
        rx_left_d  = rx_l_sr_q;
        rx_right_d = rx_r_sr_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= BIT_LAST;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      tx_sr_q     <= '0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      underrun_q  <= 1'b0;
      rx_l_sr_q   <= '0;
      rx_r_sr_q   <= '0;
      rx_pend_q   <= 1'b0;
      rx_left_q   <= '0;
      rx_right_q  <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      tx_sr_q     <= tx_sr_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      underrun_q  <= underrun_d;
      rx_l_sr_q   <= rx_l_sr_d;
      rx_r_sr_q   <= rx_r_sr_d;
      rx_pend_q   <= rx_pend_d;
      rx_left_q   <= rx_left_d;
      rx_right_q  <= rx_right_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign bus.tx_ready    = tx_ready;
  assign bus.tx_underrun = underrun_q;
  assign bus.rx_left     = rx_left_q;
  assign bus.rx_right    = rx_right_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.i2s_bclk    = bclk_q;
  assign bus.i2s_lrclk   = lrclk_q;
  assign bus.i2s_sdata_o = sdata_q;

endmodule

// File: tb/tb_adau1761_i2s_port.sv
// Directed bench for adau1761_i2s_port: DAC data looped back into the ADC input,
// frame timing tracked by an absolute clk count from enable.
module tb_adau1761_i2s_port;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;

  adau1761_i2s_if #(.SAMPLE_W(24)) bus ();

  assign bus.i2s_sdata_i = bus.i2s_sdata_o;

  adau1761_i2s_port #(.BCLK_HALF(8), .SAMPLE_W(24), .SLOT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Observations of one 1024-clk frame
  logic [63:0] f_sd, f_lr;
  logic [23:0] f_rxl, f_rxr;
  int          f_rxn, f_rxo, f_un, f_uo;
  logic        f_r0, f_r1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Called with the frame-start clk just sampled; returns at offset 1023
  task automatic run_frame(input bit push, input logic [23:0] pl, input logic [23:0] pr);
    f_sd = '0; f_lr = '0; f_rxl = '0; f_rxr = '0;
    f_rxn = 0; f_rxo = -1; f_un = 0; f_uo = -1; f_r0 = 1'b0; f_r1 = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (i == 0) begin
        f_r0 = bus.tx_ready;
        if (push) begin
          bus.tx_left = pl; bus.tx_right = pr; bus.tx_valid = 1'b1;
        end
      end
      if (i == 1) begin
        f_r1 = bus.tx_ready;
        bus.tx_valid = 1'b0;
      end
      if (i % 16 == 0) begin
        f_sd[63 - i/16] = bus.i2s_sdata_o;
        f_lr[63 - i/16] = bus.i2s_lrclk;
      end
      if (bus.rx_valid) begin
        f_rxn++; f_rxo = i; f_rxl = bus.rx_left; f_rxr = bus.rx_right;
      end
      if (bus.tx_underrun) begin
        f_un++; f_uo = i;
      end
      if (i < 1023) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    tick();
    n_vec++; if (bus.i2s_bclk !== 1'b0) begin n_err++; $display("FAIL reset_bclk: got %b want 0", bus.i2s_bclk); end
    n_vec++; if (bus.i2s_lrclk !== 1'b0) begin n_err++; $display("FAIL reset_lrclk: got %b want 0", bus.i2s_lrclk); end
    n_vec++; if (bus.i2s_sdata_o !== 1'b0) begin n_err++; $display("FAIL reset_sdata: got %b want 0", bus.i2s_sdata_o); end
    n_vec++; if ({bus.rx_valid, bus.tx_underrun, bus.tx_ready} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.rx_valid, bus.tx_underrun, bus.tx_ready}); end
    n_vec++; if ({bus.rx_left, bus.rx_right} !== 48'h0) begin n_err++; $display("FAIL reset_rx: got %h want 0", {bus.rx_left, bus.rx_right}); end
  endtask

  task automatic test_bclk_start();
    bus.enable = 1'b1;
    cyc = 0;
    ticks(7);
    n_vec++; if (bus.i2s_bclk !== 1'b0) begin n_err++; $display("FAIL bclk_pre_rise: got %b want 0", bus.i2s_bclk); end
    n_vec++; if (bus.tx_ready !== 1'b1) begin n_err++; $display("FAIL ready_enabled: got %b want 1", bus.tx_ready); end
    tick();
    n_vec++; if (bus.i2s_bclk !== 1'b1) begin n_err++; $display("FAIL bclk_first_rise: got %b want 1 at clk %0d", bus.i2s_bclk, cyc); end
  endtask

  task automatic test_tx_frame();
    bus.tx_left = 24'hA5A5A5; bus.tx_right = 24'h123456; bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    n_vec++; if (bus.tx_ready !== 1'b0) begin n_err++; $display("FAIL hold_full_ready: got %b want 0", bus.tx_ready); end
    ticks(6);
    n_vec++; if ({bus.tx_ready, bus.i2s_bclk} !== 2'b01) begin n_err++; $display("FAIL frame_start_clk: ready,bclk got %b want 01", {bus.tx_ready, bus.i2s_bclk}); end
    tick();
    n_vec++; if ({bus.tx_ready, bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata_o, bus.tx_underrun} !== 5'b10000) begin
      n_err++; $display("FAIL first_fall: ready,bclk,lrclk,sdata,underrun got %b want 10000", {bus.tx_ready, bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata_o, bus.tx_underrun}); end
    run_frame(1'b0, 24'h0, 24'h0);
    n_vec++; if (f_sd !== 64'h52D2D280_091A2B00) begin n_err++; $display("FAIL tx_frame_bits: got %h want 52d2d280091a2b00", f_sd); end
    n_vec++; if (f_lr !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL lrclk_bits: got %h want 00000000ffffffff", f_lr); end
    n_vec++; if (f_un !== 0) begin n_err++; $display("FAIL tx_frame_underrun: got %0d pulses want 0", f_un); end
    n_vec++; if (f_rxn !== 1 || f_rxo !== 905) begin n_err++; $display("FAIL rx_valid_timing0: got %0d pulses last at %0d want 1 at 905", f_rxn, f_rxo); end
    n_vec++; if ({f_rxl, f_rxr} !== 48'hA5A5A5_123456) begin n_err++; $display("FAIL rx_frame0: got %h want a5a5a5123456", {f_rxl, f_rxr}); end
    n_vec++; if (bus.i2s_lrclk !== 1'b1) begin n_err++; $display("FAIL lrclk_end_frame: got %b want 1", bus.i2s_lrclk); end
    tick();
  endtask

  task automatic test_underrun();
    run_frame(1'b0, 24'h0, 24'h0);
    n_vec++; if (f_un !== 1 || f_uo !== 0) begin n_err++; $display("FAIL underrun_pulse: got %0d pulses last at %0d want 1 at 0", f_un, f_uo); end
    n_vec++; if (f_sd !== 64'h0) begin n_err++; $display("FAIL underrun_silence: got %h want 0", f_sd); end
    n_vec++; if (f_lr !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL lrclk_period: got %h want 00000000ffffffff", f_lr); end
    n_vec++; if (f_rxn !== 1 || f_rxo !== 905 || {f_rxl, f_rxr} !== 48'h0) begin
      n_err++; $display("FAIL rx_frame1: got %0d pulses at %0d data %h want 1 at 905 data 0", f_rxn, f_rxo, {f_rxl, f_rxr}); end
  endtask

  task automatic test_bypass();
    n_vec++; if (bus.tx_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready: got %b want 1", bus.tx_ready); end
    bus.tx_left = 24'h654321; bus.tx_right = 24'hFEDCBA; bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    run_frame(1'b1, 24'hABCDEF, 24'h000001);
    n_vec++; if ({f_r0, f_r1} !== 2'b10) begin n_err++; $display("FAIL bypass_hold_ready: got %b want 10", {f_r0, f_r1}); end
    n_vec++; if (f_un !== 0) begin n_err++; $display("FAIL bypass_underrun: got %0d pulses want 0", f_un); end
    n_vec++; if (f_sd !== 64'h32A19080_7F6E5D00) begin n_err++; $display("FAIL bypass_bits: got %h want 32a190807f6e5d00", f_sd); end
    n_vec++; if ({f_rxl, f_rxr} !== 48'h654321_FEDCBA) begin n_err++; $display("FAIL rx_frame2: got %h want 654321fedcba", {f_rxl, f_rxr}); end
    n_vec++; if (bus.tx_ready !== 1'b0) begin n_err++; $display("FAIL held_start_ready: got %b want 0", bus.tx_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    run_frame(1'b1, 24'h800001, 24'h7FFFFF);
    n_vec++; if ({f_r0, f_r1} !== 2'b10) begin n_err++; $display("FAIL freed_slot_ready: got %b want 10", {f_r0, f_r1}); end
    n_vec++; if (f_sd !== 64'h55E6F780_00000080) begin n_err++; $display("FAIL held_pair_bits: got %h want 55e6f78000000080", f_sd); end
    n_vec++; if (f_un !== 0 || {f_rxl, f_rxr} !== 48'hABCDEF_000001) begin
      n_err++; $display("FAIL rx_frame3: underrun %0d data %h want 0 abcdef000001", f_un, {f_rxl, f_rxr}); end
    tick();
  endtask

  task automatic test_rx_loopback();
    run_frame(1'b0, 24'h0, 24'h0);
    n_vec++; if (f_sd !== 64'h40000080_3FFFFF80) begin n_err++; $display("FAIL loop_bits: got %h want 400000803fffff80", f_sd); end
    n_vec++; if (f_rxn !== 1 || f_rxo !== 905) begin n_err++; $display("FAIL rx_valid_timing4: got %0d pulses last at %0d want 1 at 905", f_rxn, f_rxo); end
    n_vec++; if (f_rxl !== 24'h800001) begin n_err++; $display("FAIL rx_left_edge: got %h want 800001", f_rxl); end
    n_vec++; if (f_rxr !== 24'h7FFFFF) begin n_err++; $display("FAIL rx_right_edge: got %h want 7fffff", f_rxr); end
    tick();
  endtask

  task automatic test_abort();
    int stray;
    n_vec++; if (bus.tx_underrun !== 1'b1) begin n_err++; $display("FAIL frame5_underrun: got %b want 1", bus.tx_underrun); end
    bus.tx_left = 24'h111111; bus.tx_right = 24'h222222; bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    ticks(199);
    bus.enable = 1'b0;
    tick();
    n_vec++; if ({bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata_o, bus.tx_ready} !== 4'b0000) begin
      n_err++; $display("FAIL abort_outputs: bclk,lrclk,sdata,ready got %b want 0000", {bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata_o, bus.tx_ready}); end
    n_vec++; if ({bus.rx_left, bus.rx_right} !== 48'h800001_7FFFFF) begin n_err++; $display("FAIL abort_rx_hold: got %h want 8000017fffff", {bus.rx_left, bus.rx_right}); end
    stray = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.rx_valid || bus.i2s_bclk || bus.tx_underrun) stray++;
      tick();
    end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active clks want 0", stray); end
    bus.enable = 1'b1;
    cyc = 0;
    tick();
    n_vec++; if (bus.tx_ready !== 1'b1) begin n_err++; $display("FAIL reenable_hold_empty: got %b want 1", bus.tx_ready); end
    ticks(6);
    n_vec++; if (bus.i2s_bclk !== 1'b0) begin n_err++; $display("FAIL reenable_pre_rise: got %b want 0", bus.i2s_bclk); end
    tick();
    n_vec++; if (bus.i2s_bclk !== 1'b1) begin n_err++; $display("FAIL reenable_rise: got %b want 1", bus.i2s_bclk); end
    ticks(8);
    n_vec++; if ({bus.i2s_bclk, bus.tx_underrun} !== 2'b01) begin n_err++; $display("FAIL reenable_frame_start: bclk,underrun got %b want 01", {bus.i2s_bclk, bus.tx_underrun}); end
    run_frame(1'b0, 24'h0, 24'h0);
    n_vec++; if (f_sd !== 64'h0 || f_lr !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL reenable_frame: sd %h lr %h want 0 00000000ffffffff", f_sd, f_lr); end
    n_vec++; if (f_rxn !== 1 || f_rxo !== 905 || {f_rxl, f_rxr} !== 48'h0) begin
      n_err++; $display("FAIL reenable_rx: got %0d pulses at %0d data %h want 1 at 905 data 0", f_rxn, f_rxo, {f_rxl, f_rxr}); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    cyc = 0;
    n_vec = 0;
    n_err = 0;
    bus.enable   = 1'b0;
    bus.tx_left  = '0;
    bus.tx_right = '0;
    bus.tx_valid = 1'b0;
    test_reset();
    test_bclk_start();
    test_tx_frame();
    test_underrun();
    test_bypass();
    test_back_to_back();
    test_rx_loopback();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adau1761_i2s_port.md
Name: adau1761_i2s_port

Overview:
Full-duplex I2S master serial port for the ADAU1761 codec. It sits downstream of the I2C configuration sequencer. `enable` is driven high once codec setup has completed. The block then generates BCLK/LRCLK, serialises playback samples to the codec DAC and deserialises capture samples from the codec ADC. The frame is 64 BCLK: two 32-bit slots, 24-bit MSB-first data, standard I2S one-BCLK delay.

Parameters:
BCLK_HALF, 8, clk cycles per BCLK half-period (>=2); frame = 128*BCLK_HALF clk cycles, 1024 by default (48 kHz at 49.152 MHz).
SAMPLE_W, 24, audio sample width (<=32).
SLOT_W, 32, BCLK cycles per channel slot; frame = 2*SLOT_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  port run enable (high after codec configuration done)
tx_left  in  SAMPLE_W  playback left sample
tx_right  in  SAMPLE_W  playback right sample
tx_valid  in  1  playback sample pair valid
tx_ready  out  1  holding register can accept a pair
tx_underrun  out  1  one-clk pulse: frame started with no sample available
rx_left  out  SAMPLE_W  last captured left sample
rx_right  out  SAMPLE_W  last captured right sample
rx_valid  out  1  one-clk pulse: new rx pair presented
i2s_bclk  out  1  bit clock to codec
i2s_lrclk  out  1  word select (0 = left slot)
i2s_sdata_o  out  1  DAC serial data
i2s_sdata_i  in  1  ADC serial data

Behaviour:
Reset is clk/rst: synchronous, active-high; all state is clocked on posedge clk.
- Reset / enable=0:
  - bclk, lrclk, sdata_o, rx_valid, tx_underrun = 0; rx_left/rx_right = 0 (reset only; they hold when only enable is low).
  - div_cnt = 0; bit_cnt = 2*SLOT_W-1; holding register emptied.
  - Deasserting enable mid-frame aborts immediately into this state.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1; at BCLK_HALF-1 it wraps and bclk toggles.
  - A 0->1 toggle is a "rise event"; a 1->0 toggle is a "fall event".
  - After enable rises, the first toggle is a rise event, BCLK_HALF clk cycles later.
- Fall event: bit_cnt increments modulo 2*SLOT_W (first fall after enable wraps 63->0). With new value b:
  - lrclk = (b >= SLOT_W).
  - b==0 is frame start: the shift register loads the frame {L, zero pad, R, zero pad}, and sdata_o = 0.
  - b=1..63: sdata_o = frame bit b-1, MSB first (one-BCLK I2S delay). Pad bits are 0.
- TX handshake:
  - tx_ready = enable & ~hold_full (combinational).
  - Accept on tx_valid & tx_ready; a one-pair holding register captures tx_left/tx_right.
  - At a frame-start clk: if hold_full, load from hold and clear full.
  - Else, if a handshake occurs in that same clk, bypass the incoming pair straight into the shift register; no underrun.
  - Else load zeros (silence) and pulse tx_underrun for 1 clk.
  - On the frame-start clk, if hold_full, tx_ready stays 0 for that clk; the freed slot becomes ready the next clk.
- RX, at each rise event with current bit_cnt b:
  - b in 1..SAMPLE_W: capture sdata_i into left shift register MSB-first.
  - b in SLOT_W+1..SLOT_W+SAMPLE_W: capture into right shift register.
  - Other bits are ignored.
  - On the clk after the rise event with b = SLOT_W+SAMPLE_W (56): copy both to rx_left/rx_right and pulse rx_valid for 1 clk.
  - Outputs hold until the next frame.
  - The partial frame after enable (bit_cnt 63, no fall yet) captures nothing; no rx_valid before a complete frame.
- Timing: all outputs are registered except tx_ready. bclk duty is exactly 50%. Frame period is exactly 128*BCLK_HALF clk.

Test Plan:
- Reset then enable=1, BCLK_HALF=8 -> bclk first rises 8 clk after enable; lrclk falls/stays 0 at first fall; lrclk period 1024 clk, high 512 clk.
- Push tx pair L=0xA5A5A5, R=0x123456 before first frame -> sdata_o = 0 at bit 0, then bits 1..24 = A5A5A5 MSB-first, 25..32 = 0, 33..56 = 123456, 57..63 = 0; tx_ready returns 1 the clk after frame start.
- No tx_valid across a frame start -> tx_underrun single 1-clk pulse; all 64 sdata_o bits = 0.
- tx_valid presented exactly on the frame-start clk with hold empty -> pair appears in that frame, no underrun; second pair held until next frame, tx_ready=0 meanwhile.
- Loop sdata_o to sdata_i with L=0x800001, R=0x7FFFFF -> rx_valid 1-clk pulse one clk after the 56th-bit rise event; rx_left=0x800001, rx_right=0x7FFFFF.
- Drop enable mid-left-slot, re-enable -> bclk/lrclk/sdata_o 0 immediately, hold emptied, rx_valid not pulsed for aborted frame; restart timing identical to post-reset.
